// File: rtl/mips_defs_pkg.sv
// mips_defs: memory map, reset/handler addresses and exception codes shared across the core.
package mips_defs;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_TOP    = 32'h0000_6FFC;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  function automatic logic addr_err(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a[1:0] != 2'b00) || (a < lo) || (a > hi);
  endfunction
endpackage

// File: rtl/fetch_stage_fd_reg.sv
// fd_reg: F/D pipeline register; flush beats stall, stall holds every field.
module fd_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        adel_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [4:0]  excode_o,
  output logic        bd_o
);
  logic [31:0] instr_q, pc_q, pc4_q;
  logic [4:0]  excode_q;
  logic        bd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      pc_q     <= '0;
      pc4_q    <= '0;
      excode_q <= EXC_NONE;
      bd_q     <= 1'b0;
    end else if (flush_i) begin
      instr_q  <= '0;
      pc_q     <= pc_i;
      pc4_q    <= pc_i + 32'd4;
      excode_q <= EXC_NONE;
      bd_q     <= 1'b0;
    end else if (!stall_i) begin
      instr_q  <= adel_i ? 32'd0 : instr_i;
      pc_q     <= pc_i;
      pc4_q    <= pc_i + 32'd4;
      excode_q <= adel_i ? EXC_ADEL : EXC_NONE;
      bd_q     <= bd_i;
    end
  end
  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign pc4_o    = pc4_q;
  assign excode_o = excode_q;
  assign bd_o     = bd_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register with exception/eret/redirect priority mux, AdEL check and F/D register.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
  parameter logic [31:0] EXC_ENTRY = mips_defs::EXC_ENTRY,
  parameter logic [31:0] IM_BASE   = mips_defs::IM_BASE,
  parameter logic [31:0] IM_TOP    = mips_defs::IM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        change,
  input  logic [31:0] pc_new,
  input  logic        is_jump_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic [4:0]  excode_D,
  output logic        bd_D
);
  logic [31:0] pc_q, pc_d;
  logic        adel_f, eret_go;
  assign adel_f  = addr_err(pc_q, IM_BASE, IM_TOP);
  assign eret_go = eret_req && !stall;
  // exception ignores stall; a stalled eret waits like any other D instruction
  always_comb pc_d = exc_req ? EXC_ENTRY : eret_go ? epc : stall ? pc_q : change ? pc_new : pc_q + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  assign pc_F = pc_q;
  fd_reg u_fd (
    .clk(clk),
    .rst(reset),
    .stall_i(stall),
    .flush_i(exc_req || eret_go),
    .adel_i(adel_f),
    .bd_i(is_jump_D),
    .pc_i(pc_q),
    .instr_i(instr_F),
    .instr_o(instr_D),
    .pc_o(pc_D),
    .pc4_o(pc4_D),
    .excode_o(excode_D),
    .bd_o(bd_D)
  );
endmodule
